// File: rtl/noise_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : noise_lfsr_checker
// Brief    : Receive-side lock/error checker for the 24-bit LFSR noise source.
// Revision : 1.0 - initial release
// ============================================================================
module noise_lfsr_checker #(
    parameter int WIDTH    = 24,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_noise,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_lost,
    output logic [CNT_W-1:0] o_samples,
    output logic [CNT_W-1:0] o_err_words,
    output logic [CNT_W-1:0] o_err_bits
);

    localparam int         c_POP_W     = $clog2(WIDTH + 1);
    localparam logic [8:0] c_LOCK_RUN  = 9'(LOCK_CNT);
    localparam logic [8:0] c_LOSS_RUN  = 9'(LOSS_CNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_ref, w_ref_nxt;
    logic [7:0]         r_run, w_run_nxt;
    logic               r_lost, w_lost_nxt;
    logic [CNT_W-1:0]   r_samples, r_err_words, r_err_bits;
    logic [CNT_W-1:0]   w_samples_nxt, w_err_words_nxt, w_err_bits_nxt;
    logic [CNT_W-1:0]   w_base_samples, w_base_err_words, w_base_err_bits;
    logic [WIDTH-1:0]   w_diff;
    logic [c_POP_W-1:0] w_pop;
    logic [8:0]         w_run_inc;
    logic               w_match, w_zero, w_count;

    // Fibonacci step for x^24+x^23+x^22+x^17+1
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], x[23] ^ x[22] ^ x[21] ^ x[16]};
    endfunction

    // Saturating add: an overflowing sum clamps to all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [c_POP_W-1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + (CNT_W + 1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign w_match   = (i_noise == r_ref);
    assign w_zero    = (i_noise == '0);
    assign w_diff    = i_noise ^ r_ref;
    assign w_run_inc = {1'b0, r_run} + 9'd1;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + c_POP_W'(w_diff[i]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ref_nxt   = r_ref;
        w_run_nxt   = r_run;
        w_lost_nxt  = 1'b0;
        w_count     = 1'b0;
        if (i_valid) begin
            case (r_state)
                HUNT: begin
                    if (!w_zero) begin
                        w_ref_nxt   = lfsr_next(i_noise);
                        w_run_nxt   = '0;
                        w_state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (w_match) begin
                        w_ref_nxt = lfsr_next(i_noise);
                        if (w_run_inc == c_LOCK_RUN) begin
                            w_state_nxt = LOCKED;
                            w_run_nxt   = '0;
                        end else begin
                            w_run_nxt = w_run_inc[7:0];
                        end
                    end else if (w_zero) begin
                        w_state_nxt = HUNT;
                        w_run_nxt   = '0;
                    end else begin
                        w_ref_nxt = lfsr_next(i_noise);
                        w_run_nxt = '0;
                    end
                end
                LOCKED: begin
                    // Free-running prediction: received words never reseed here
                    w_ref_nxt = lfsr_next(r_ref);
                    w_count   = 1'b1;
                    if (w_match) begin
                        w_run_nxt = '0;
                    end else if (w_run_inc == c_LOSS_RUN) begin
                        w_state_nxt = HUNT;
                        w_run_nxt   = '0;
                        w_lost_nxt  = 1'b1;
                    end else begin
                        w_run_nxt = w_run_inc[7:0];
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    // Clear zeroes the base so a same-cycle sample lands on a fresh counter
    always_comb begin
        w_base_samples   = i_clear ? '0 : r_samples;
        w_base_err_words = i_clear ? '0 : r_err_words;
        w_base_err_bits  = i_clear ? '0 : r_err_bits;
        w_samples_nxt    = w_base_samples;
        w_err_words_nxt  = w_base_err_words;
        w_err_bits_nxt   = w_base_err_bits;
        if (w_count) begin
            w_samples_nxt = sat_add(w_base_samples, c_POP_W'(1));
            if (!w_match) begin
                w_err_words_nxt = sat_add(w_base_err_words, c_POP_W'(1));
                w_err_bits_nxt  = sat_add(w_base_err_bits, w_pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= HUNT;
            r_ref       <= '0;
            r_run       <= '0;
            r_lost      <= 1'b0;
            r_samples   <= '0;
            r_err_words <= '0;
            r_err_bits  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ref       <= w_ref_nxt;
            r_run       <= w_run_nxt;
            r_lost      <= w_lost_nxt;
            r_samples   <= w_samples_nxt;
            r_err_words <= w_err_words_nxt;
            r_err_bits  <= w_err_bits_nxt;
        end
    end

    assign o_locked    = (r_state == LOCKED);
    assign o_lost      = r_lost;
    assign o_samples   = r_samples;
    assign o_err_words = r_err_words;
    assign o_err_bits  = r_err_bits;

endmodule
`default_nettype wire

// File: tb/tb_noise_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_noise_lfsr_checker
// Brief    : Self-checking bench for noise_lfsr_checker against a spec-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noise_lfsr_checker;

    localparam int  CNT_W    = 12;
    localparam int  LOCK_CNT = 16;
    localparam int  LOSS_CNT = 4;
    localparam longint CMAX  = (64'd1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid = 1'b0;
    logic [23:0]      noise = '0;
    logic             clear = 1'b0;
    logic             locked, lost;
    logic [CNT_W-1:0] samples, err_words, err_bits;

    int n_tests = 0;
    int n_fail  = 0;

    noise_lfsr_checker #(
        .WIDTH(24), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_noise(noise), .i_clear(clear),
        .o_locked(locked), .o_lost(lost), .o_samples(samples),
        .o_err_words(err_words), .o_err_bits(err_bits)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0=hunt, 1=sync, 2=locked
    int          m_mode = 0;
    logic [23:0] m_ref  = '0;
    int          m_run  = 0;
    bit          m_lost = 1'b0;
    longint      m_samp = 0, m_ew = 0, m_eb = 0;

    function automatic logic [23:0] gnext(input logic [23:0] x);
        return {x[22:0], x[23] ^ x[22] ^ x[21] ^ x[16]};
    endfunction

    function automatic longint sat(input longint a, input longint b);
        return (a + b > CMAX) ? CMAX : a + b;
    endfunction

    task automatic model_update(input logic v, input logic [23:0] n, input logic clr, input logic r);
        if (r) begin
            m_mode = 0; m_ref = '0; m_run = 0; m_lost = 0;
            m_samp = 0; m_ew = 0; m_eb = 0;
            return;
        end
        m_lost = 0;
        if (clr) begin
            m_samp = 0; m_ew = 0; m_eb = 0;
        end
        if (!v) return;
        if (m_mode == 0) begin
            if (n != 0) begin
                m_ref = gnext(n); m_run = 0; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (n == m_ref) begin
                m_ref = gnext(n);
                m_run++;
                if (m_run == LOCK_CNT) begin
                    m_mode = 2; m_run = 0;
                end
            end else if (n == 0) begin
                m_mode = 0; m_run = 0;
            end else begin
                m_ref = gnext(n); m_run = 0;
            end
        end else begin
            m_samp = sat(m_samp, 1);
            if (n != m_ref) begin
                m_ew = sat(m_ew, 1);
                m_eb = sat(m_eb, $countones(n ^ m_ref));
                m_run++;
                if (m_run == LOSS_CNT) begin
                    m_mode = 0; m_lost = 1; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_ref = gnext(m_ref);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge
    task automatic step(input logic v, input logic [23:0] n, input logic clr, input logic r);
        @(negedge clk);
        valid = v; noise = n; clear = clr; rst = r;
        model_update(v, n, clr, r);
        @(posedge clk);
        #1;
        check("locked",    32'(locked),    32'(m_mode == 2));
        check("lost",      32'(lost),      32'(m_lost));
        check("samples",   32'(samples),   32'(m_samp));
        check("err_words", 32'(err_words), 32'(m_ew));
        check("err_bits",  32'(err_bits),  32'(m_eb));
    endtask

    logic [23:0] g, w, mask;
    int          vcnt, lock_at, gap;
    bit          lost_seen;

    // Send clean generator words (with optional idle gaps) until lock; returns valids used
    task automatic run_to_lock(input int gap_cycles, output int at);
        at = -1;
        vcnt = 0;
        for (int k = 0; k < 40 && at < 0; k++) begin
            step(1'b1, g, 1'b0, 1'b0);
            g = gnext(g);
            vcnt++;
            if (locked === 1'b1) at = vcnt;
            for (int j = 0; j < gap_cycles; j++) step(1'b0, 24'($urandom), 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Reset state
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_samples", 32'(samples), 32'd0);

        // Clean stream from seed 1, every cycle
        g = 24'h000001;
        run_to_lock(0, lock_at);
        check("lock_latency_clean", 32'(lock_at), 32'd17);
        step(1'b1, '0, 1'b1, 1'b0);
        g = gnext(g);
        check("clear_with_zero_word", 32'(err_words), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            step(1'b1, g, 1'b0, 1'b0);
            g = gnext(g);
        end
        check("clean_samples", 32'(samples), 32'd1000);
        check("clean_err_words", 32'(err_words), 32'd0);
        check("clean_err_bits", 32'(err_bits), 32'd0);

        // Single corruption while locked, then no propagation
        step(1'b1, g ^ 24'h000007, 1'b0, 1'b0);
        g = gnext(g);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, g, 1'b0, 1'b0);
            g = gnext(g);
        end
        check("single_err_words", 32'(err_words), 32'd1);
        check("single_err_bits", 32'(err_bits), 32'd3);
        check("single_lock_held", 32'(locked), 32'd1);

        // Random isolated corruptions with random gaps
        for (int k = 0; k < 200; k++) begin
            w = g;
            if ((k % 2 == 0) && ($urandom_range(0, 3) == 0)) w = g ^ 24'($urandom_range(1, 24'hFFFFFF));
            step(1'b1, w, 1'b0, 1'b0);
            g = gnext(g);
            gap = $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) step(1'b0, 24'($urandom), 1'b0, 1'b0);
        end
        check("random_lock_held", 32'(locked), 32'd1);

        // Burst of LOSS_CNT corrupted words drops lock
        lost_seen = 0;
        for (int k = 0; k < LOSS_CNT; k++) begin
            mask = 24'($urandom_range(1, 24'hFFFFFF));
            step(1'b1, g ^ mask, 1'b0, 1'b0);
            g = gnext(g);
            if (k < LOSS_CNT - 1 && lost === 1'b1) lost_seen = 1;
        end
        check("burst_no_early_lost", 32'(lost_seen), 32'd0);
        check("burst_lost_pulse", 32'(lost), 32'd1);
        check("burst_unlocked", 32'(locked), 32'd0);
        run_to_lock(0, lock_at);
        check("relock_latency", 32'(lock_at), 32'd17);

        // HUNT robustness: zeros, then a SYNC mismatch at run 10
        step(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b1, 24'h0, 1'b0, 1'b0);
        g = 24'($urandom_range(1, 24'hFFFFFF));
        for (int k = 0; k < 11; k++) begin
            step(1'b1, g, 1'b0, 1'b0);
            g = gnext(g);
        end
        w = g ^ 24'($urandom_range(1, 24'hFFFFFF));
        if (w == 0) w = 24'h800000;
        step(1'b1, w, 1'b0, 1'b0);
        g = gnext(w);
        lock_at = -1;
        for (int k = 0; k < 40 && lock_at < 0; k++) begin
            step(1'b1, g, 1'b0, 1'b0);
            g = gnext(g);
            if (locked === 1'b1) lock_at = k + 1;
        end
        check("hunt_matches_after_reseed", 32'(lock_at), 32'd16);

        // Sparse valids: one every 128 cycles
        step(1'b0, '0, 1'b0, 1'b1);
        g = 24'($urandom_range(1, 24'hFFFFFF));
        run_to_lock(127, lock_at);
        check("sparse_lock_latency", 32'(lock_at), 32'd17);

        // Bit-counter saturation with alternating all-bit errors
        step(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 180; k++) begin
            step(1'b1, g ^ 24'hFFFFFF, 1'b0, 1'b0);
            g = gnext(g);
            step(1'b1, g, 1'b0, 1'b0);
            g = gnext(g);
        end
        check("sat_err_bits", 32'(err_bits), 32'hFFF);
        check("sat_err_words", 32'(err_words), 32'd180);
        check("sat_samples", 32'(samples), 32'd360);

        // Clear coincident with a counted mismatching valid
        step(1'b1, g ^ 24'h000005, 1'b1, 1'b0);
        g = gnext(g);
        check("clear_samples", 32'(samples), 32'd1);
        check("clear_err_words", 32'(err_words), 32'd1);
        check("clear_err_bits", 32'(err_bits), 32'd2);

        // Reset mid-lock
        check("pre_reset_locked", 32'(locked), 32'd1);
        step(1'b1, g, 1'b1, 1'b1);
        check("midreset_locked", 32'(locked), 32'd0);
        check("midreset_samples", 32'(samples), 32'd0);
        check("midreset_err_bits", 32'(err_bits), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
